alu_operand_sequencer: RTL and testbench
========================================

# alu_operand_sequencer

Upstream issue stage for ALU_DESIGN. Accepts one ALU operation per valid/ready handshake and drives the ALU input pins (INP_VALID, OPA, OPB, CMD, MODE, CIN, CE), either as a single full beat or as two split operand beats separated by a programmable gap. It then waits the command-dependent ALU latency and pulses RES_STROBE in the cycle the consumer must sample the ALU outputs.

## Interface
- DW, 8, operand width
- CW, 4, command width
- ARITH_LAT, 2, cycles from final issue beat to RES_STROBE (all commands except multiply)
- MUL_LAT, 4, same for MODE=1 CMD 4'h9 / 4'hA
- GAP_LIMIT, 16, ALU split-operand window in cycles

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  reset; synchronous and active-high
- REQ_VALID  in  1  request present
- REQ_READY  out  1  sequencer can accept
- REQ_OPA, REQ_OPB  in  DW  operands
- REQ_CMD  in  CW  command
- REQ_MODE, REQ_CIN  in  1  mode, carry-in
- REQ_SPLIT  in  1  1 = deliver operands in two beats
- REQ_ORDER  in  1  split only: 0 = OPA first (01 then 10), 1 = OPB first
- REQ_GAP  in  5  idle cycles between split beats
- ALU_INP_VALID  out  2  to ALU INP_VALID
- ALU_OPA, ALU_OPB  out  DW  to ALU
- ALU_CMD  out  CW  to ALU
- ALU_MODE, ALU_CIN, ALU_CE  out  1  to ALU
- RES_STROBE  out  1  one-cycle pulse: ALU outputs valid now
- GAP_ERR  out  1  one-cycle pulse, see Configuration
- ISSUE_CNT  out  8  completed-operation count

## Operation
- Every output is registered.
- States: IDLE, FULL, BEAT1, GAP, BEAT2, WAIT.
- IDLE:
  - REQ_READY=1; ALU_INP_VALID=00.
  - On REQ_VALID, latch all REQ_* fields.
  - REQ_SPLIT=0 → FULL. REQ_SPLIT=1 → BEAT1.
- FULL: ALU_INP_VALID=11 for one cycle → WAIT.
- BEAT1:
  - Drives first operand for one cycle: 01 with ALU_OPA valid, or 10 with ALU_OPB valid, per REQ_ORDER.
  - → GAP if REQ_GAP>0, else → BEAT2.
- GAP: ALU_INP_VALID=00 for exactly REQ_GAP cycles → BEAT2.
- BEAT2: drives the other operand code for one cycle → WAIT.
- WAIT:
  - ALU_INP_VALID=00; counter loads ARITH_LAT or MUL_LAT.
  - MUL_LAT applies only when latched MODE=1 and CMD ∈ {9, A}.
  - RES_STROBE asserts in the final WAIT cycle; next state is IDLE.
- ALU_CMD, ALU_MODE and ALU_CIN hold the latched values from the accept cycle until the next accept. ALU_OPA and ALU_OPB hold likewise.
- ALU_CE=1 during reset and in every state except IDLE; ALU_CE=0 in IDLE, which freezes the ALU outputs.
- ISSUE_CNT increments on each RES_STROBE and wraps 255→0.
- REQ_READY=0 in all states except IDLE. A request held during busy is not accepted and must stay stable.

## Timing
- RST=1 at an edge forces the following, regardless of state:
  - state=IDLE
  - REQ_READY=0 during the reset cycle and 1 from the first cycle after
  - ALU_INP_VALID=00; ALU_OPA/OPB/CMD/MODE/CIN=0; ALU_CE=1
  - RES_STROBE=0, GAP_ERR=0, ISSUE_CNT=0
- Reset mid-operation discards the transaction; no strobe follows.
- Accept at edge k:
  - FULL beat in cycle k+1.
  - RES_STROBE in cycle k+1+ARITH_LAT (non-multiply).
- Split: BEAT1 in k+1, BEAT2 in k+2+REQ_GAP, strobe in k+2+REQ_GAP+LAT.
- Back-to-back throughput: one operation per 2+LAT cycles (full) or 3+REQ_GAP+LAT cycles (split). The next accept is possible in the cycle after RES_STROBE.
- REQ_GAP=0: the two beats are adjacent.
- REQ_GAP=31: the maximum; the counter must not wrap.

## Configuration
- ALU_SEQ_GAP_CHECK_EN defined:
  - On accept of a split request with REQ_GAP ≥ GAP_LIMIT, GAP_ERR pulses in cycle k+1.
  - The request is still issued unchanged, so the ALU timeout path stays exercisable.
- Undefined: GAP_ERR is tied 0 and the comparator is absent.

## Structure
- Package alu_seq_pkg holds:
  - the state enum
  - ARITH_LAT/MUL_LAT/GAP_LIMIT defaults
  - ALU command constants CMD_INC_MUL=4'h9 and CMD_SHL_SUB=4'hA
  - INP_VALID codes IV_NONE/IV_A/IV_B/IV_AB
- Sub-module alu_seq_down_cnt is a loadable 5-bit down-counter with zero flag. It is shared by the GAP and WAIT states.

## Test plan
- Full add: OPA=8'h0F, OPB=8'h01, MODE=1, CMD=0 → one cycle of INP_VALID=11, RES_STROBE 2 cycles later, ALU RES=9'h010.
- Split A-first, GAP=3: OPA=8'h05, OPB=8'h03, MODE=1, CMD=1 → sequence 01, 00×3, 10; strobe 2 cycles after the 10 beat; RES=2.
- Multiply: MODE=1, CMD=9, OPA=2, OPB=3 → strobe 4 cycles after the beat; RES=12; ISSUE_CNT increments by 1.
- GAP=16 with ALU_SEQ_GAP_CHECK_EN → GAP_ERR pulses in the cycle after accept; beats are still issued. GAP=15 → no pulse.
- Reset during the GAP state:
  - in the following cycle, ALU_INP_VALID=00, REQ_READY=0 and no RES_STROBE;
  - REQ_READY=1 in the cycle after that.
- Back-to-back: 256 full requests with REQ_VALID held high → one accept every 4 cycles; ISSUE_CNT wraps to 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFull,
        StBeat1,
        StGap,
        StBeat2,
        StWait
    } seq_state_e;

    localparam int unsigned ARITH_LAT_DEFAULT = 2;
    localparam int unsigned MUL_LAT_DEFAULT   = 4;
    localparam int unsigned GAP_LIMIT_DEFAULT = 16;

    localparam logic [3:0] CMD_INC_MUL = 4'h9;
    localparam logic [3:0] CMD_SHL_SUB = 4'hA;

    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_AB   = 2'b11;

    // Multiply-class commands only exist in arithmetic mode.
    function automatic logic is_mul_op(input logic mode, input logic [3:0] cmd);
        return mode && (cmd == CMD_INC_MUL || cmd == CMD_SHL_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_down_cnt.sv
// Loadable 5-bit down-counter with zero flag; paces both the split gap and the result latency.
module alu_seq_down_cnt (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [4:0] load_val,
    input  logic       dec,
    output logic [4:0] count,
    output logic       zero
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= 5'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != 5'd0) begin
            count <= count - 5'd1;
        end
    end

    assign zero = (count == 5'd0);

endmodule

// File: rtl/alu_operand_sequencer.sv
// Issue stage for the ALU: drives full or split operand beats, then strobes the result.
// Optional GAP_ERR comparator enabled by defining ALU_SEQ_GAP_CHECK_EN.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned CW        = 4,
    parameter int unsigned ARITH_LAT = ARITH_LAT_DEFAULT,
    parameter int unsigned MUL_LAT   = MUL_LAT_DEFAULT
`ifdef ALU_SEQ_GAP_CHECK_EN
    ,
    parameter int unsigned GAP_LIMIT = GAP_LIMIT_DEFAULT
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [DW-1:0] REQ_OPA,
    input  logic [DW-1:0] REQ_OPB,
    input  logic [CW-1:0] REQ_CMD,
    input  logic          REQ_MODE,
    input  logic          REQ_CIN,
    input  logic          REQ_SPLIT,
    input  logic          REQ_ORDER,
    input  logic [4:0]    REQ_GAP,
    output logic [1:0]    ALU_INP_VALID,
    output logic [DW-1:0] ALU_OPA,
    output logic [DW-1:0] ALU_OPB,
    output logic [CW-1:0] ALU_CMD,
    output logic          ALU_MODE,
    output logic          ALU_CIN,
    output logic          ALU_CE,
    output logic          RES_STROBE,
    output logic          GAP_ERR,
    output logic [7:0]    ISSUE_CNT
);

    localparam logic [4:0] ARITH_M1 = 5'(ARITH_LAT - 1);
    localparam logic [4:0] MUL_M1   = 5'(MUL_LAT - 1);

    seq_state_e state;
    logic       order_q;
    logic [4:0] gap_q;

    logic       cnt_load;
    logic       cnt_dec;
    logic [4:0] cnt_val;
    logic [4:0] cnt;
    logic       cnt_zero;
    logic [4:0] lat_m1;
    logic [1:0] second_iv;
    logic       fire;
    logic       gap_over;

`ifdef ALU_SEQ_GAP_CHECK_EN
    assign gap_over = REQ_SPLIT && (32'(REQ_GAP) >= GAP_LIMIT);
`else
    assign gap_over = 1'b0;
`endif

    assign lat_m1    = is_mul_op(ALU_MODE, 4'(ALU_CMD)) ? MUL_M1 : ARITH_M1;
    assign second_iv = order_q ? IV_A : IV_B;

    // Strobe is registered, so raise it one edge before the final WAIT cycle.
    assign fire = ((state == StFull || state == StBeat2) && lat_m1 == 5'd0) ||
                  (state == StWait && cnt == 5'd1);

    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = lat_m1;
        unique case (state)
            StBeat1: begin
                cnt_load = (gap_q != 5'd0);
                cnt_val  = gap_q - 5'd1;
            end
            StFull, StBeat2: cnt_load = 1'b1;
            StGap, StWait:   cnt_dec  = 1'b1;
            default: ;
        endcase
    end

    alu_seq_down_cnt u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= StIdle;
            order_q       <= 1'b0;
            gap_q         <= 5'd0;
            REQ_READY     <= 1'b0;
            ALU_INP_VALID <= IV_NONE;
            ALU_OPA       <= '0;
            ALU_OPB       <= '0;
            ALU_CMD       <= '0;
            ALU_MODE      <= 1'b0;
            ALU_CIN       <= 1'b0;
            ALU_CE        <= 1'b1;
            RES_STROBE    <= 1'b0;
            GAP_ERR       <= 1'b0;
            ISSUE_CNT     <= 8'd0;
        end else begin
            RES_STROBE <= fire;
            GAP_ERR    <= 1'b0;
            if (fire) begin
                ISSUE_CNT <= ISSUE_CNT + 8'd1;
            end
            unique case (state)
                StIdle: begin
                    ALU_CE    <= 1'b0;
                    REQ_READY <= 1'b1;
                    if (REQ_VALID && REQ_READY) begin
                        ALU_OPA   <= REQ_OPA;
                        ALU_OPB   <= REQ_OPB;
                        ALU_CMD   <= REQ_CMD;
                        ALU_MODE  <= REQ_MODE;
                        ALU_CIN   <= REQ_CIN;
                        order_q   <= REQ_ORDER;
                        gap_q     <= REQ_GAP;
                        ALU_CE    <= 1'b1;
                        REQ_READY <= 1'b0;
                        GAP_ERR   <= gap_over;
                        if (REQ_SPLIT) begin
                            state         <= StBeat1;
                            ALU_INP_VALID <= REQ_ORDER ? IV_B : IV_A;
                        end else begin
                            state         <= StFull;
                            ALU_INP_VALID <= IV_AB;
                        end
                    end
                end
                StFull: begin
                    ALU_INP_VALID <= IV_NONE;
                    state         <= StWait;
                end
                StBeat1: begin
                    if (gap_q != 5'd0) begin
                        ALU_INP_VALID <= IV_NONE;
                        state         <= StGap;
                    end else begin
                        ALU_INP_VALID <= second_iv;
                        state         <= StBeat2;
                    end
                end
                StGap: begin
                    if (cnt_zero) begin
                        ALU_INP_VALID <= second_iv;
                        state         <= StBeat2;
                    end
                end
                StBeat2: begin
                    ALU_INP_VALID <= IV_NONE;
                    state         <= StWait;
                end
                StWait: begin
                    if (cnt_zero) begin
                        state     <= StIdle;
                        REQ_READY <= 1'b1;
                        ALU_CE    <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench: driver predicts per-cycle beat/strobe events, a monitor pops and compares.
module tb_alu_operand_sequencer;

    typedef struct {
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
        logic       split;
        logic       order;
        logic [4:0] gap;
    } req_t;

    typedef struct {
        int         cyc;
        logic [1:0] iv;
        logic       strobe;
        logic       gerr;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [7:0] REQ_OPA = '0;
    logic [7:0] REQ_OPB = '0;
    logic [3:0] REQ_CMD = '0;
    logic       REQ_MODE = 1'b0;
    logic       REQ_CIN = 1'b0;
    logic       REQ_SPLIT = 1'b0;
    logic       REQ_ORDER = 1'b0;
    logic [4:0] REQ_GAP = '0;
    logic [1:0] ALU_INP_VALID;
    logic [7:0] ALU_OPA;
    logic [7:0] ALU_OPB;
    logic [3:0] ALU_CMD;
    logic       ALU_MODE;
    logic       ALU_CIN;
    logic       ALU_CE;
    logic       RES_STROBE;
    logic       GAP_ERR;
    logic [7:0] ISSUE_CNT;

    alu_operand_sequencer dut (
        .CLK           (CLK),
        .RST           (RST),
        .REQ_VALID     (REQ_VALID),
        .REQ_READY     (REQ_READY),
        .REQ_OPA       (REQ_OPA),
        .REQ_OPB       (REQ_OPB),
        .REQ_CMD       (REQ_CMD),
        .REQ_MODE      (REQ_MODE),
        .REQ_CIN       (REQ_CIN),
        .REQ_SPLIT     (REQ_SPLIT),
        .REQ_ORDER     (REQ_ORDER),
        .REQ_GAP       (REQ_GAP),
        .ALU_INP_VALID (ALU_INP_VALID),
        .ALU_OPA       (ALU_OPA),
        .ALU_OPB       (ALU_OPB),
        .ALU_CMD       (ALU_CMD),
        .ALU_MODE      (ALU_MODE),
        .ALU_CIN       (ALU_CIN),
        .ALU_CE        (ALU_CE),
        .RES_STROBE    (RES_STROBE),
        .GAP_ERR       (GAP_ERR),
        .ISSUE_CNT     (ISSUE_CNT)
    );

    always #5 CLK = ~CLK;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   cnt_chk_cyc = -1;
    logic mon_en = 1'b0;
    ev_t  exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input req_t r);
        return (r.mode && (r.cmd == 4'h9 || r.cmd == 4'hA)) ? 4 : 2;
    endfunction

    // Predict every visible event of one request, given the cycle its first beat appears.
    task automatic expect_req(input req_t r, input int a);
        ev_t  e;
        int   lat;
        logic gerr;
        lat = lat_of(r);
`ifdef ALU_SEQ_GAP_CHECK_EN
        gerr = r.split && (r.gap >= 5'd16);
`else
        gerr = 1'b0;
`endif
        e.opa = r.opa; e.opb = r.opb; e.cmd = r.cmd; e.mode = r.mode; e.cin = r.cin;
        e.strobe = 1'b0;
        if (!r.split) begin
            e.cyc = a; e.iv = 2'b11; e.gerr = 1'b0;
            exp_q.push_back(e);
            e.cyc = a + lat; e.iv = 2'b00; e.strobe = 1'b1;
            exp_q.push_back(e);
        end else begin
            e.cyc = a; e.iv = r.order ? 2'b10 : 2'b01; e.gerr = gerr;
            exp_q.push_back(e);
            e.cyc = a + 1 + int'(r.gap); e.iv = r.order ? 2'b01 : 2'b10; e.gerr = 1'b0;
            exp_q.push_back(e);
            e.cyc = a + 1 + int'(r.gap) + lat; e.iv = 2'b00; e.strobe = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge CLK) begin
        ev_t e;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("missed_event_cycle", 32'(cyc), 32'(e.cyc));
            end
            if (cnt_chk_cyc == cyc) begin
                chk("issue_cnt", 32'(ISSUE_CNT), 32'(exp_cnt % 256));
                cnt_chk_cyc = -1;
            end
            if (ALU_INP_VALID != 2'b00 || RES_STROBE || GAP_ERR) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    chk("unexpected_output", {29'd0, ALU_INP_VALID, RES_STROBE | GAP_ERR}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("inp_valid", 32'(ALU_INP_VALID), 32'(e.iv));
                    chk("res_strobe", 32'(RES_STROBE), 32'(e.strobe));
                    chk("gap_err", 32'(GAP_ERR), 32'(e.gerr));
                    chk("alu_ce_busy", 32'(ALU_CE), 32'd1);
                    chk("req_ready_busy", 32'(REQ_READY), 32'd0);
                    chk("alu_opa", 32'(ALU_OPA), 32'(e.opa));
                    chk("alu_opb", 32'(ALU_OPB), 32'(e.opb));
                    chk("alu_ctl", {23'd0, ALU_CMD, ALU_MODE, ALU_CIN}, {23'd0, e.cmd, e.mode, e.cin});
                    if (e.strobe) begin
                        exp_cnt++;
                        cnt_chk_cyc = cyc + 1;
                    end
                end
            end
        end
    end

    // Caller is at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input req_t r, output int acc);
        int waited = 0;
        REQ_OPA = r.opa; REQ_OPB = r.opb; REQ_CMD = r.cmd; REQ_MODE = r.mode;
        REQ_CIN = r.cin; REQ_SPLIT = r.split; REQ_ORDER = r.order; REQ_GAP = r.gap;
        REQ_VALID = 1'b1;
        while (REQ_READY !== 1'b1 && waited < 100) begin
            @(negedge CLK);
            waited++;
        end
        if (REQ_READY !== 1'b1) begin
            chk("accept_timeout", 32'(REQ_READY), 32'd1);
            REQ_VALID = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        expect_req(r, acc);
        @(negedge CLK);
        REQ_VALID = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        RST = 1'b1;
        REQ_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        cnt_chk_cyc = -1;
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_inp_valid", 32'(ALU_INP_VALID), 32'd0);
        chk("rst_ce", 32'(ALU_CE), 32'd1);
        chk("rst_strobe_err", {30'd0, RES_STROBE, GAP_ERR}, 32'd0);
        chk("rst_issue_cnt", 32'(ISSUE_CNT), 32'd0);
        chk("rst_operands", {ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, 2'b00}, 32'd0);
        @(negedge CLK);
        chk("post_rst_ready", 32'(REQ_READY), 32'd1);
        chk("post_rst_ce_idle", 32'(ALU_CE), 32'd0);
        mon_en = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        chk("idle_ready", 32'(REQ_READY), 32'd1);
        chk("idle_ce", 32'(ALU_CE), 32'd0);
    endtask

    function automatic req_t mk(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                                input logic m, input logic s, input logic o, input logic [4:0] g);
        req_t r;
        r.opa = a; r.opb = b; r.cmd = c; r.mode = m; r.cin = 1'b0;
        r.split = s; r.order = o; r.gap = g;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.opa   = 8'($urandom);
        r.opb   = 8'($urandom);
        r.cmd   = 4'($urandom);
        r.mode  = 1'($urandom);
        r.cin   = 1'($urandom);
        r.split = 1'($urandom);
        r.order = 1'($urandom);
        r.gap   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
        return r;
    endfunction

    initial begin
        int   acc;
        int   prev;
        req_t r;

        do_reset();

        issue(mk(8'h0F, 8'h01, 4'h0, 1'b1, 1'b0, 1'b0, 5'd0), acc);
        issue(mk(8'h05, 8'h03, 4'h1, 1'b1, 1'b1, 1'b0, 5'd3), acc);
        issue(mk(8'h02, 8'h03, 4'h9, 1'b1, 1'b0, 1'b0, 5'd0), acc);
        issue(mk(8'hA5, 8'h5A, 4'hA, 1'b1, 1'b1, 1'b1, 5'd0), acc);
        issue(mk(8'h11, 8'h22, 4'h9, 1'b0, 1'b1, 1'b1, 5'd31), acc);
        issue(mk(8'h33, 8'h44, 4'h2, 1'b0, 1'b1, 1'b0, 5'd16), acc);
        issue(mk(8'h55, 8'h66, 4'h3, 1'b1, 1'b1, 1'b1, 5'd15), acc);
        drain();

        for (int i = 0; i < 40; i++) begin
            int idle = $urandom_range(0, 3);
            for (int j = 0; j < idle; j++) @(negedge CLK);
            issue(rand_req(), acc);
        end
        drain();

        // Abort a split transaction while it is in its gap.
        issue(mk(8'h77, 8'h88, 4'h0, 1'b1, 1'b1, 1'b0, 5'd10), acc);
        @(negedge CLK);
        @(negedge CLK);
        exp_q.delete();
        do_reset();
        for (int j = 0; j < 20; j++) @(negedge CLK);
        chk("no_strobe_after_abort", 32'(exp_cnt), 32'd0);

        prev = -1;
        for (int i = 0; i < 256; i++) begin
            r = rand_req();
            r.split = 1'b0;
            if (r.mode && (r.cmd == 4'h9 || r.cmd == 4'hA)) r.cmd = 4'h0;
            issue(r, acc);
            if (prev >= 0 && (i % 32) == 1) chk("b2b_spacing", 32'(acc - prev), 32'd4);
            prev = acc;
        end
        drain();
        chk("issue_cnt_wrap", 32'(ISSUE_CNT), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
